// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
//   Top-level layer scheduler for the inference datapath. Drives the shared cs
//   state bus through IDLE -> LAYER0 -> LAYER1 -> LAYER2 -> LAYER3 -> AFFINE ->
//   IDLE. For each layer it waits for the weight banks to report loaded, pulses
//   layer_start to the compute engine, and advances on layer_done.
//   After each cs change, w_valid is ignored for SETTLE cycles, because the
//   weight stores still show the valid from the previous layer.
//
// Optional feature macro: SEQ_WATCHDOG_EN
//   Defined: a TIMEOUT-cycle watchdog runs on every LOAD phase. On expiry it
//   sets a sticky error, returns cs to IDLE and drops busy without pulsing
//   done. start is ignored while error is set.
//   Undefined: no watchdog counter exists, TIMEOUT is not a parameter, error
//   is tied to 0 and LOAD waits indefinitely.
//
// Parameters
//   SETTLE   cycles after a cs change during which w_valid is ignored
//   TIMEOUT  max cycles spent in LOAD (SEQ_WATCHDOG_EN only)
//
// Ports
//   clk          in   1  system clock, posedge
//   rst          in   1  synchronous active-high reset
//   start        in   1  begin one inference pass (sampled only when idle)
//   w_valid      in   1  AND of all weight_store valid outputs
//   layer_done   in   1  compute engine finished current layer
//   cs           out  4  layer state bus (codes match state_layer_data.v)
//   layer_start  out  1  1-cycle pulse: weights ready, compute may begin
//   layer_idx    out  3  0..4 = LAYER0..LAYER3, AFFINE; 0 when idle
//   busy         out  1  pass in progress
//   done         out  1  1-cycle pulse at end of pass
//   error        out  1  sticky watchdog flag
// ---------------------------------------------------------------------------
module layer_sequencer #(
    parameter int SETTLE = 2
`ifdef SEQ_WATCHDOG_EN
    ,
    parameter int TIMEOUT = 1024
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       w_valid,
    input  logic       layer_done,
    output logic [3:0] cs,
    output logic       layer_start,
    output logic [2:0] layer_idx,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // cs bus codes; these must stay identical to state_layer_data.v
    localparam logic [3:0] CS_IDLE   = 4'd0;
    localparam logic [3:0] CS_LAYER0 = 4'd1;
    localparam logic [3:0] CS_LAYER1 = 4'd2;
    localparam logic [3:0] CS_LAYER2 = 4'd3;
    localparam logic [3:0] CS_LAYER3 = 4'd4;
    localparam logic [3:0] CS_AFFINE = 4'd5;

    localparam logic [2:0] LAST_IDX = 3'd4;
    localparam int         BW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

    function automatic logic [3:0] layer_code(input logic [2:0] idx);
        case (idx)
            3'd0:    layer_code = CS_LAYER0;
            3'd1:    layer_code = CS_LAYER1;
            3'd2:    layer_code = CS_LAYER2;
            3'd3:    layer_code = CS_LAYER3;
            default: layer_code = CS_AFFINE;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      cs_q, cs_d;
    logic            layer_start_q, layer_start_d;
    logic [2:0]      idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [BW-1:0]   blank_q, blank_d;
    logic            load_accept;
    logic            enter_load;
    logic            start_ok;

`ifdef SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0]  wd_q, wd_d;
    logic            error_q, error_d;

    assign start_ok = start & ~error_q;
    assign error    = error_q;
`else
    assign start_ok = start;
    assign error    = 1'b0;
`endif

    // Weights count as ready only once the blanking window has expired.
    assign load_accept = (blank_q == '0) && w_valid;

    always_comb begin
        // NOTE: every next-state value is defaulted first so no latch is inferred.
        state_d       = state_q;
        cs_d          = cs_q;
        layer_start_d = 1'b0;
        idx_d         = idx_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        blank_d       = blank_q;
        enter_load    = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        wd_d          = wd_q;
        error_d       = error_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d    = S_LOAD;
                    cs_d       = CS_LAYER0;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    blank_d    = BW'(SETTLE);
                    enter_load = 1'b1;
                end
            end
            S_LOAD: begin
                if (blank_q != '0) begin
                    blank_d = blank_q - BW'(1);
                end else if (w_valid) begin
                    layer_start_d = 1'b1;
                    state_d       = S_RUN;
                end
            end
            S_RUN: begin
                if (layer_done) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d      = idx_q + 3'd1;
                        cs_d       = layer_code(idx_q + 3'd1);
                        blank_d    = BW'(SETTLE);
                        state_d    = S_LOAD;
                        enter_load = 1'b1;
                    end else begin
                        // Outputs are registered, so the done pulse and the
                        // return of cs to IDLE are launched from here.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        cs_d    = CS_IDLE;
                        idx_d   = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SEQ_WATCHDOG_EN
        // The counter holds the number of LOAD cycles already spent, so the
        // TIMEOUT-th cycle without acceptance trips the watchdog.
        if (state_q == S_LOAD && !load_accept) begin
            if (wd_q == WDW'(TIMEOUT - 1)) begin
                error_d = 1'b1;
                state_d = S_IDLE;
                cs_d    = CS_IDLE;
                idx_d   = '0;
                busy_d  = 1'b0;
                blank_d = '0;
            end else begin
                wd_d = wd_q + WDW'(1);
            end
        end
        if (enter_load) begin
            wd_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset clears every register, counters included,
        // so a reset mid-pass aborts cleanly without a done pulse.
        if (rst) begin
            state_q       <= S_IDLE;
            cs_q          <= CS_IDLE;
            layer_start_q <= 1'b0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            blank_q       <= '0;
`ifdef SEQ_WATCHDOG_EN
            wd_q          <= '0;
            error_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so all registers update together.
            state_q       <= state_d;
            cs_q          <= cs_d;
            layer_start_q <= layer_start_d;
            idx_q         <= idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            blank_q       <= blank_d;
`ifdef SEQ_WATCHDOG_EN
            wd_q          <= wd_d;
            error_q       <= error_d;
`endif
        end
    end

    assign cs          = cs_q;
    assign layer_start = layer_start_q;
    assign layer_idx   = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_layer_sequencer
//   Self-checking bench for layer_sequencer. Random w_valid / start /
//   layer_done traffic; expected outputs come from the sequencing rules:
//   a layer's weights are accepted on the first cycle at least SETTLE cycles
//   after its cs change where w_valid is high, and each layer_done advances
//   to the next layer code (or ends the pass after AFFINE).
//   Define SEQ_WATCHDOG_EN to also exercise the watchdog with TIMEOUT=16.
// ---------------------------------------------------------------------------
module tb_layer_sequencer;

    localparam int SETTLE     = 2;
    localparam int TIMEOUT_TB = 16;

    // Layer codes indexed by position in the pass: 0 = IDLE, 1..5 = L0..AFFINE
    localparam logic [3:0] CODE [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       w_valid;
    logic       layer_done;
    logic [3:0] cs;
    logic       layer_start;
    logic [2:0] layer_idx;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layer_sequencer #(
        .SETTLE(SETTLE)
`ifdef SEQ_WATCHDOG_EN
        ,
        .TIMEOUT(TIMEOUT_TB)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .w_valid    (w_valid),
        .layer_done (layer_done),
        .cs         (cs),
        .layer_start(layer_start),
        .layer_idx  (layer_idx),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_cs, input int e_idx,
                             input logic e_ls, input logic e_busy, input logic e_done,
                             input logic e_err);
        check({tag, ".cs"},          32'(cs),          32'(e_cs));
        check({tag, ".layer_idx"},   32'(layer_idx),   32'(e_idx));
        check({tag, ".layer_start"}, 32'(layer_start), 32'(e_ls));
        check({tag, ".busy"},        32'(busy),        32'(e_busy));
        check({tag, ".done"},        32'(done),        32'(e_done));
        check({tag, ".error"},       32'(error),       32'(e_err));
    endtask

    // One inference pass. abort_layer in 0..4 asserts reset during that
    // layer's compute phase instead of finishing the pass.
    task automatic run_pass(input int abort_layer);
        bit accepted;
        int k;
        int n;
        start      = 1'b1;
        w_valid    = 1'($urandom_range(0, 1));
        layer_done = 1'b0;
        step();
        check_all("start", CODE[1], 0, 1'b0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        for (int l = 0; l < 5; l++) begin
            // Weight load: stale valid held high through the blanking window.
            k        = 0;
            accepted = 1'b0;
            while (!accepted) begin
                if (k < SETTLE)  w_valid = 1'b1;
                else if (k > 40) w_valid = 1'b1;
                else             w_valid = 1'($urandom_range(0, 1));
                layer_done = ($urandom_range(0, 3) == 0);
                start      = ($urandom_range(0, 3) == 0);
                accepted   = (k >= SETTLE) && w_valid;
                step();
                check_all("load", CODE[l + 1], l, accepted, 1'b1, 1'b0, 1'b0);
                k++;
            end
            // Compute: random wait with noise on w_valid and start.
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) begin
                w_valid    = 1'($urandom_range(0, 1));
                start      = 1'($urandom_range(0, 1));
                layer_done = 1'b0;
                step();
                check_all("run", CODE[l + 1], l, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            if (l == abort_layer) begin
                rst        = 1'b1;
                start      = 1'b0;
                layer_done = 1'b0;
                step();
                check_all("abort", CODE[0], 0, 1'b0, 1'b0, 1'b0, 1'b0);
                rst = 1'b0;
                step();
                check_all("abort_idle", CODE[0], 0, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            layer_done = 1'b1;
            start      = 1'($urandom_range(0, 1));
            step();
            if (l < 4) check_all("advance", CODE[l + 2], l + 1, 1'b0, 1'b1, 1'b0, 1'b0);
            else       check_all("last", CODE[0], 0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        layer_done = 1'b0;
        start      = 1'b0;
        w_valid    = 1'($urandom_range(0, 1));
        step();
        check_all("post", CODE[0], 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL time_limit observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        w_valid    = 1'b0;
        layer_done = 1'b0;

        // Reset for 3 cycles, then idle for 5 with noise on the data inputs.
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("reset", CODE[0], 0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w_valid    = 1'($urandom_range(0, 1));
            layer_done = 1'($urandom_range(0, 1));
            step();
            check_all("idle", CODE[0], 0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        layer_done = 1'b0;

        for (int p = 0; p < 4; p++) run_pass(-1);

        // Reset in the compute phase of LAYER3, then a clean pass.
        run_pass(3);
        run_pass(-1);

`ifdef SEQ_WATCHDOG_EN
        // Weights never load: error after TIMEOUT_TB LOAD cycles.
        start   = 1'b1;
        w_valid = 1'b0;
        step();
        check_all("wd_start", CODE[1], 0, 1'b0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        for (int i = 1; i < TIMEOUT_TB; i++) begin
            step();
            check_all("wd_wait", CODE[1], 0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        step();
        check_all("wd_trip", CODE[0], 0, 1'b0, 1'b0, 1'b0, 1'b1);
        start   = 1'b1;
        w_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_all("wd_locked", CODE[0], 0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        start = 1'b0;
        rst   = 1'b1;
        step();
        check_all("wd_reset", CODE[0], 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        run_pass(-1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
